// File: rtl/rv32i_instruction_encoder_if.sv
// Handshake bundle between a field producer and the RV32I instruction encoder.
// Master drives the field set and out_ready; slave (the encoder) drives the encoded word side.
interface rv32i_instruction_encoder_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_kind;
    logic [3:0]       in_alu_op;
    logic [2:0]       in_funct3;
    logic             in_auipc;
    logic [4:0]       in_rd;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic [31:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_err;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_kind, in_alu_op, in_funct3, in_auipc,
               in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err, out_count
    );

    modport slave (
        input  in_valid, in_kind, in_alu_op, in_funct3, in_auipc,
               in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_err, out_count
    );
endinterface

// File: rtl/rv32i_instruction_encoder.sv
// RV32I field-to-word encoder with an output FIFO and emitted-instruction counter.
// Optional immediate range checking is enabled by defining ENCODER_RANGE_CHECK_EN.
module rv32i_instruction_encoder #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic rst_n,
    rv32i_instruction_encoder_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] K_ALU_REG = 3'd0;
    localparam logic [2:0] K_ALU_IMM = 3'd1;
    localparam logic [2:0] K_LOAD    = 3'd2;
    localparam logic [2:0] K_STORE   = 3'd3;
    localparam logic [2:0] K_BRANCH  = 3'd4;
    localparam logic [2:0] K_JAL     = 3'd5;
    localparam logic [2:0] K_JALR    = 3'd6;
    localparam logic [2:0] K_UPPER   = 3'd7;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] imm;
    logic [2:0]  alu_f3;
    logic [6:0]  alu_f7;
    logic        alu_bad;
    logic        is_shift;
    logic        range_bad;
    logic [31:0] raw_instr;
    logic        enc_err;
    logic [31:0] enc_instr;

    assign imm = bus.in_imm;

    always_comb begin
        alu_f3   = 3'b000;
        alu_f7   = 7'h00;
        alu_bad  = 1'b0;
        is_shift = 1'b0;
        case (bus.in_alu_op)
            OP_ADD: alu_f3 = 3'b000;
            OP_SUB: begin alu_f3 = 3'b000; alu_f7 = 7'h20; end
            OP_AND: alu_f3 = 3'b111;
            OP_OR:  alu_f3 = 3'b110;
            OP_XOR: alu_f3 = 3'b100;
            OP_SLT: alu_f3 = 3'b010;
            OP_SLL: begin alu_f3 = 3'b001; is_shift = 1'b1; end
            OP_SRL: begin alu_f3 = 3'b101; is_shift = 1'b1; end
            OP_SRA: begin alu_f3 = 3'b101; alu_f7 = 7'h20; is_shift = 1'b1; end
            default: alu_bad = 1'b1;
        endcase
    end

    always_comb begin
        raw_instr = NOP;
        case (bus.in_kind)
            K_ALU_REG: raw_instr = {alu_f7, bus.in_rs2, bus.in_rs1, alu_f3, bus.in_rd, 7'h33};
            K_ALU_IMM: begin
                if (is_shift)
                    raw_instr = {alu_f7, imm[4:0], bus.in_rs1, alu_f3, bus.in_rd, 7'h13};
                else
                    raw_instr = {imm[11:0], bus.in_rs1, alu_f3, bus.in_rd, 7'h13};
            end
            K_LOAD:    raw_instr = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, 7'h03};
            K_STORE:   raw_instr = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                                    imm[4:0], 7'h23};
            K_BRANCH:  raw_instr = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                                    imm[4:1], imm[11], 7'h63};
            K_JAL:     raw_instr = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, 7'h6F};
            K_JALR:    raw_instr = {imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, 7'h67};
            K_UPPER:   raw_instr = {imm[31:12], bus.in_rd, (bus.in_auipc ? 7'h17 : 7'h37)};
            default:   raw_instr = NOP;
        endcase
    end

`ifdef ENCODER_RANGE_CHECK_EN
    logic i_ok;
    logic b_ok;
    logic j_ok;

    // A value fits an N-bit signed field when all bits above the field's sign bit match it.
    assign i_ok = (&imm[31:11]) | ~(|imm[31:11]);
    assign b_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
    assign j_ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];

    always_comb begin
        range_bad = 1'b0;
        case (bus.in_kind)
            K_ALU_IMM: range_bad = is_shift ? (|imm[31:5]) : ~i_ok;
            K_LOAD,
            K_STORE,
            K_JALR:    range_bad = ~i_ok;
            K_BRANCH:  range_bad = ~b_ok;
            K_JAL:     range_bad = ~j_ok;
            K_UPPER:   range_bad = |imm[11:0];
            default:   range_bad = 1'b0;
        endcase
    end
`else
    assign range_bad = 1'b0;
`endif

    always_comb begin
        enc_err = range_bad;
        if (bus.in_kind == K_ALU_REG || bus.in_kind == K_ALU_IMM) begin
            if (alu_bad)
                enc_err = 1'b1;
            if (bus.in_kind == K_ALU_IMM && bus.in_alu_op == OP_SUB)
                enc_err = 1'b1;
        end
        enc_instr = enc_err ? NOP : raw_instr;
    end

    // FIFO entry is {err, instr}; the extra pointer bit separates full from empty.
    logic [32:0]      mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [32:0]      head;
    logic [CNT_W-1:0] count;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = bus.in_valid && !full;
    assign pop   = !empty && bus.out_ready;
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {enc_err, enc_instr};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                count  <= count + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_instr = empty ? 32'h0 : head[31:0];
    assign bus.out_err   = empty ? 1'b0 : head[32];
    assign bus.out_count = count;
endmodule

// File: tb/tb_rv32i_instruction_encoder.sv
// Directed, table-driven bench for the RV32I instruction encoder (FIFO_DEPTH=2).
module tb_rv32i_instruction_encoder;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   exp_count;

    rv32i_instruction_encoder_if #(.CNT_W(16)) bus ();

    rv32i_instruction_encoder #(.FIFO_DEPTH(2), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  kind;
        logic [3:0]  op;
        logic [2:0]  f3;
        logic        auipc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic [2:0] kind, logic [3:0] op, logic [2:0] f3,
                                logic auipc, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                logic [31:0] imm, logic [31:0] exp_instr, logic exp_err);
        vec_t v;
        v.name = name; v.kind = kind; v.op = op; v.f3 = f3; v.auipc = auipc;
        v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.exp_instr = exp_instr; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        bus.in_kind   = v.kind;
        bus.in_alu_op = v.op;
        bus.in_funct3 = v.f3;
        bus.in_auipc  = v.auipc;
        bus.in_rd     = v.rd;
        bus.in_rs1    = v.rs1;
        bus.in_rs2    = v.rs2;
        bus.in_imm    = v.imm;
    endtask

    // One vector through an empty FIFO: accept, check one-cycle latency and contents, pop.
    task automatic apply(vec_t v);
        @(negedge clk);
        drive(v);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        chk({v.name, " in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({v.name, " valid_before"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({v.name, " valid_after"}, 32'(bus.out_valid), 32'd1);
        chk({v.name, " instr"}, bus.out_instr, v.exp_instr);
        chk({v.name, " err"}, 32'(bus.out_err), 32'(v.exp_err));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        exp_count++;
        chk({v.name, " drained"}, 32'(bus.out_valid), 32'd0);
        chk({v.name, " count"}, 32'(bus.out_count), 32'(exp_count));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t a;
        vec_t b;
        vec_t c;
        checks    = 0;
        errors    = 0;
        exp_count = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_kind   = '0;
        bus.in_alu_op = '0;
        bus.in_funct3 = '0;
        bus.in_auipc  = 1'b0;
        bus.in_rd     = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_imm    = '0;

        vecs.push_back(mk("add_reg",  3'd0, 4'd0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0,         32'h003100B3, 1'b0));
        vecs.push_back(mk("addi_m1",  3'd1, 4'd0, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF,  32'hFFF00093, 1'b0));
        vecs.push_back(mk("srai",     3'd1, 4'd8, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'd3,         32'h40315093, 1'b0));
        vecs.push_back(mk("sw",       3'd3, 4'd0, 3'd2, 1'b0, 5'd0, 5'd2, 5'd5, 32'd8,         32'h00512423, 1'b0));
        vecs.push_back(mk("beq_m4",   3'd4, 4'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC,  32'hFE000EE3, 1'b0));
        vecs.push_back(mk("lui",      3'd7, 4'd0, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000,  32'h123452B7, 1'b0));
        vecs.push_back(mk("auipc",    3'd7, 4'd0, 3'd0, 1'b1, 5'd1, 5'd0, 5'd0, 32'h00001000,  32'h00001097, 1'b0));
        vecs.push_back(mk("lw_m8",    3'd2, 4'd0, 3'd2, 1'b0, 5'd3, 5'd4, 5'd0, 32'hFFFFFFF8,  32'hFF822183, 1'b0));
        vecs.push_back(mk("jal_2048", 3'd5, 4'd0, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048,      32'h001000EF, 1'b0));
        vecs.push_back(mk("jalr",     3'd6, 4'd0, 3'd5, 1'b0, 5'd0, 5'd1, 5'd0, 32'd4,         32'h00408067, 1'b0));
        vecs.push_back(mk("sub_reg",  3'd0, 4'd1, 3'd0, 1'b0, 5'd5, 5'd6, 5'd7, 32'd0,         32'h407302B3, 1'b0));
        vecs.push_back(mk("slli_31",  3'd1, 4'd6, 3'd0, 1'b0, 5'd2, 5'd2, 5'd0, 32'd31,        32'h01F11113, 1'b0));
        vecs.push_back(mk("and_reg",  3'd0, 4'd2, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0,         32'h0010F0B3, 1'b0));
        vecs.push_back(mk("subi_bad", 3'd1, 4'd1, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'd5,         32'h00000013, 1'b1));
        vecs.push_back(mk("op9_bad",  3'd0, 4'd9, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0,         32'h00000013, 1'b1));
`ifdef ENCODER_RANGE_CHECK_EN
        vecs.push_back(mk("addi_4096", 3'd1, 4'd0, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4096,     32'h00000013, 1'b1));
        vecs.push_back(mk("beq_odd",   3'd4, 4'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd3,        32'h00000013, 1'b1));
        vecs.push_back(mk("slli_big",  3'd1, 4'd6, 3'd0, 1'b0, 5'd2, 5'd2, 5'd0, 32'd32,       32'h00000013, 1'b1));
`else
        vecs.push_back(mk("addi_4096", 3'd1, 4'd0, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4096,     32'h00000093, 1'b0));
`endif

        #1;
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst out_instr", bus.out_instr, 32'd0);
        chk("rst out_err", 32'(bus.out_err), 32'd0);
        chk("rst out_count", 32'(bus.out_count), 32'd0);
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // Reset while two entries are buffered: everything drops asynchronously.
        a = vecs[0];
        b = vecs[3];
        @(negedge clk);
        drive(a);
        bus.in_valid = 1'b1;
        @(negedge clk);
        drive(b);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("pre_rst full", 32'(bus.in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        exp_count = 0;
        chk("mid_rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst out_count", 32'(bus.out_count), 32'd0);
        chk("mid_rst in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        apply(vecs[1]);

        // Backpressure: third push stalls until a slot frees; order preserved.
        a = mk("a", 3'd0, 4'd0, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0, 32'h000000B3, 1'b0);
        b = mk("b", 3'd0, 4'd0, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd0, 32'h00000133, 1'b0);
        c = mk("c", 3'd0, 4'd0, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd0, 32'h000001B3, 1'b0);
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(a);
        bus.in_valid = 1'b1;
        @(negedge clk);
        drive(b);
        @(negedge clk);
        chk("bp full after 2", 32'(bus.in_ready), 32'd0);
        chk("bp head a", bus.out_instr, a.exp_instr);
        drive(c);
        @(negedge clk);
        chk("bp still full", 32'(bus.in_ready), 32'd0);
        chk("bp head still a", bus.out_instr, a.exp_instr);
        bus.out_ready = 1'b1;
        @(negedge clk);
        exp_count++;
        chk("bp head b", bus.out_instr, b.exp_instr);
        chk("bp ready after pop", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        exp_count++;
        bus.in_valid = 1'b0;
        chk("bp head c", bus.out_instr, c.exp_instr);
        chk("bp valid c", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        exp_count++;
        bus.out_ready = 1'b0;
        chk("bp drained", 32'(bus.out_valid), 32'd0);
        chk("bp count", 32'(bus.out_count), 32'(exp_count));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
